circuit8_sched: RTL and testbench

Multi-cycle scheduler that evaluates the CIRCUIT8 function (e, f, g, equality compare against `zero`, select to `z`) on a single shared DATAWIDTH-bit add/subtract unit instead of three parallel arithmetic units. It sits between an operand producer and a result consumer, using valid/ready handshakes on both sides. It sequences the four operation steps through an FSM and holds the result until it is accepted.

---
 rtl/circuit8_sched_if.sv | 25 ++
 rtl/circuit8_sched.sv | 115 +++++++++++
 tb/tb_circuit8_sched.sv | 252 +++++++++++++++++++++++++
 3 files changed

// File: rtl/circuit8_sched_if.sv
// Operand/result handshake bundle for circuit8_sched.
// The slave side is the scheduler; the master side is the producer/consumer pair.
interface circuit8_sched_if #(parameter int DATAWIDTH = 64);
  logic                 in_valid;
  logic                 in_ready;
  logic [DATAWIDTH-1:0] a;
  logic [DATAWIDTH-1:0] b;
  logic [DATAWIDTH-1:0] c;
  logic [DATAWIDTH-1:0] zero;
  logic                 out_valid;
  logic                 out_ready;
  logic [DATAWIDTH-1:0] z;
  logic                 gEQz;
  logic                 busy;

  modport slave (
    input  in_valid, a, b, c, zero, out_ready,
    output in_ready, out_valid, z, gEQz, busy
  );

  modport master (
    output in_valid, a, b, c, zero, out_ready,
    input  in_ready, out_valid, z, gEQz, busy
  );
endinterface

// File: rtl/circuit8_sched.sv
// CIRCUIT8 (e=a+b, f=a-c, g=e-f, z = (g==zero) ? e : f) evaluated over several
// cycles on one shared add/subtract unit, with valid/ready on both sides.
//
//   state | meaning
//   IDLE  | in_ready high, waiting for operands
//   OP_E  | re <= ra + rb
//   OP_F  | rf <= ra - rc
//   OP_G  | rg <= re - rf
//   CMP   | gEQz/z updated from rg == rzero
//   OUT   | out_valid high until out_ready
module circuit8_sched #(
  parameter int DATAWIDTH = 64
) (
  input  logic            clk,
  input  logic            rst_n,
  circuit8_sched_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    OP_E = 3'd1,
    OP_F = 3'd2,
    OP_G = 3'd3,
    CMP  = 3'd4,
    OUT  = 3'd5
  } state_t;

  state_t state, state_nxt;

  logic [DATAWIDTH-1:0] ra, rb, rc, rzero;
  logic [DATAWIDTH-1:0] re, rf, rg;
  logic [DATAWIDTH-1:0] z_q;
  logic                 geq_q;

  logic [DATAWIDTH-1:0] alu_a, alu_b, alu_y;
  logic                 alu_sub;

  // Subtraction as invert-B plus carry-in, so one adder serves all three steps.
  always_comb begin
    alu_a   = ra;
    alu_b   = rb;
    alu_sub = 1'b0;
    case (state)
      OP_F: begin
        alu_b   = rc;
        alu_sub = 1'b1;
      end
      OP_G: begin
        alu_a   = re;
        alu_b   = rf;
        alu_sub = 1'b1;
      end
      default: ;
    endcase
  end

  assign alu_y = alu_a + (alu_b ^ {DATAWIDTH{alu_sub}}) + {{(DATAWIDTH-1){1'b0}}, alu_sub};

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.in_valid) state_nxt = OP_E;
      OP_E:    state_nxt = OP_F;
      OP_F:    state_nxt = OP_G;
      OP_G:    state_nxt = CMP;
      CMP:     state_nxt = OUT;
      OUT:     if (bus.out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ra    <= '0;
      rb    <= '0;
      rc    <= '0;
      rzero <= '0;
      re    <= '0;
      rf    <= '0;
      rg    <= '0;
      z_q   <= '0;
      geq_q <= 1'b0;
    end else begin
      case (state)
        IDLE: if (bus.in_valid) begin
          ra    <= bus.a;
          rb    <= bus.b;
          rc    <= bus.c;
          rzero <= bus.zero;
        end
        OP_E: re <= alu_y;
        OP_F: rf <= alu_y;
        OP_G: rg <= alu_y;
        CMP: begin
          geq_q <= (rg == rzero);
          z_q   <= (rg == rzero) ? re : rf;
        end
        default: ;
      endcase
    end
  end

  // Handshake outputs come straight from the state register: no input-to-output paths.
  assign bus.in_ready  = (state == IDLE);
  assign bus.busy      = (state != IDLE);
  assign bus.out_valid = (state == OUT);
  assign bus.z         = z_q;
  assign bus.gEQz      = geq_q;

endmodule

// File: tb/tb_circuit8_sched.sv
// Randomized self-checking bench for circuit8_sched against a plain-arithmetic model.
module tb_circuit8_sched;

  localparam int DW = 64;

  logic clk;
  logic rst_n;
  int   vectors;
  int   miscompares;

  circuit8_sched_if #(.DATAWIDTH(DW)) bus ();

  circuit8_sched #(.DATAWIDTH(DW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [DW:0] model(input logic [DW-1:0] ma, mb, mc, mz);
    logic [DW-1:0] e, f, g;
    e = ma + mb;
    f = ma - mc;
    g = e - f;
    return (g == mz) ? {1'b1, e} : {1'b0, f};
  endfunction

  function automatic logic [DW-1:0] rnd64();
    return {$urandom, $urandom};
  endfunction

  // One transaction; while busy the producer keeps offering junk operands, which must be ignored.
  task automatic run_txn(input logic [DW-1:0] ta, tb_, tc, tz, input int bp, input string name);
    logic [DW:0]   exp;
    logic [DW-1:0] hold_z;
    logic          hold_eq;
    int            lat;
    exp = model(ta, tb_, tc, tz);
    @(negedge clk);
    vectors++;
    if (bus.in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL %s idle_in_ready: got %b want 1", name, bus.in_ready);
    end
    bus.a = ta; bus.b = tb_; bus.c = tc; bus.zero = tz;
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b0;
    @(negedge clk);
    lat = 0;
    while (bus.out_valid !== 1'b1 && lat < 20) begin
      bus.a = rnd64(); bus.b = rnd64(); bus.c = rnd64(); bus.zero = rnd64();
      @(negedge clk);
      lat++;
    end
    vectors++;
    if (lat != 4) begin
      miscompares++;
      $display("FAIL %s latency: got %0d want 4", name, lat);
    end
    vectors++;
    if (bus.z !== exp[DW-1:0]) begin
      miscompares++;
      $display("FAIL %s z: got %h want %h", name, bus.z, exp[DW-1:0]);
    end
    vectors++;
    if (bus.gEQz !== exp[DW]) begin
      miscompares++;
      $display("FAIL %s gEQz: got %b want %b", name, bus.gEQz, exp[DW]);
    end
    hold_z  = exp[DW-1:0];
    hold_eq = exp[DW];
    for (int i = 0; i < bp; i++) begin
      bus.a = rnd64(); bus.b = rnd64();
      @(negedge clk);
      vectors++;
      if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 || bus.z !== hold_z || bus.gEQz !== hold_eq) begin
        miscompares++;
        $display("FAIL %s backpressure_hold[%0d]: got ov=%b ir=%b z=%h eq=%b want ov=1 ir=0 z=%h eq=%b",
                 name, i, bus.out_valid, bus.in_ready, bus.z, bus.gEQz, hold_z, hold_eq);
      end
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    vectors++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.busy !== 1'b0) begin
      miscompares++;
      $display("FAIL %s release: got ir=%b ov=%b busy=%b want ir=1 ov=0 busy=0",
               name, bus.in_ready, bus.out_valid, bus.busy);
    end
  endtask

  task automatic test_reset();
    vectors++;
    if (bus.in_ready !== 1'b1 || bus.busy !== 1'b0 || bus.out_valid !== 1'b0 ||
        bus.z !== '0 || bus.gEQz !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_values: got ir=%b busy=%b ov=%b z=%h eq=%b want ir=1 busy=0 ov=0 z=0 eq=0",
               bus.in_ready, bus.busy, bus.out_valid, bus.z, bus.gEQz);
    end
  endtask

  task automatic test_not_equal();
    run_txn(64'd5, 64'd3, 64'd2, 64'd6, 0, "not_equal");
  endtask

  task automatic test_equal();
    run_txn(64'd5, 64'd3, 64'd2, 64'd5, 0, "equal");
  endtask

  task automatic test_wrap();
    run_txn(64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'd0, 64'd1, 0, "wrap");
  endtask

  task automatic test_backpressure();
    run_txn(64'd5, 64'd3, 64'd2, 64'd6, 10, "backpressure");
  endtask

  task automatic test_reset_mid_op();
    @(negedge clk);
    bus.a = 64'd100; bus.b = 64'd7; bus.c = 64'd9; bus.zero = 64'd16;
    bus.in_valid = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    vectors++;
    if (bus.out_valid !== 1'b0 || bus.z !== '0 || bus.gEQz !== 1'b0 ||
        bus.in_ready !== 1'b1 || bus.busy !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_mid_op: got ov=%b z=%h eq=%b ir=%b busy=%b want ov=0 z=0 eq=0 ir=1 busy=0",
               bus.out_valid, bus.z, bus.gEQz, bus.in_ready, bus.busy);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      vectors++;
      if (bus.out_valid !== 1'b0) begin
        miscompares++;
        $display("FAIL post_reset_stale[%0d]: got out_valid=%b want 0", i, bus.out_valid);
      end
    end
    run_txn(64'd5, 64'd3, 64'd2, 64'd5, 0, "post_reset");
  endtask

  task automatic test_random();
    logic [DW-1:0] ra, rb, rc, rz;
    for (int n = 0; n < 12; n++) begin
      ra = rnd64(); rb = rnd64(); rc = rnd64();
      rz = ($urandom_range(0, 1) == 1) ? rb + rc : rnd64();
      run_txn(ra, rb, rc, rz, $urandom_range(0, 3), $sformatf("random%0d", n));
    end
  endtask

  task automatic test_back_to_back();
    logic [DW-1:0] oa[3], ob[3], oc[3], oz[3];
    logic [DW:0]   expq[$];
    logic [DW:0]   exp;
    int            hs[$];
    int            idx;
    int            got;
    bit            just_hs;
    for (int i = 0; i < 3; i++) begin
      oa[i] = rnd64(); ob[i] = rnd64(); oc[i] = rnd64();
      oz[i] = (i == 1) ? ob[i] + oc[i] : rnd64();
    end
    idx = 0; got = 0; just_hs = 1'b0;
    @(negedge clk);
    bus.out_ready = 1'b1;
    bus.a = oa[0]; bus.b = ob[0]; bus.c = oc[0]; bus.zero = oz[0];
    bus.in_valid = 1'b1;
    for (int cyc = 0; cyc < 60 && got < 3; cyc++) begin
      if (cyc > 0) @(negedge clk);
      if (bus.out_valid === 1'b1 && expq.size() > 0) begin
        exp = expq.pop_front();
        got++;
        vectors++;
        if (bus.z !== exp[DW-1:0] || bus.gEQz !== exp[DW]) begin
          miscompares++;
          $display("FAIL b2b_result[%0d]: got z=%h eq=%b want z=%h eq=%b",
                   got - 1, bus.z, bus.gEQz, exp[DW-1:0], exp[DW]);
        end
      end
      if (just_hs) begin
        just_hs = 1'b0;
        if (idx < 3) begin
          bus.a = oa[idx]; bus.b = ob[idx]; bus.c = oc[idx]; bus.zero = oz[idx];
        end else begin
          bus.in_valid = 1'b0;
        end
      end
      if (bus.in_ready === 1'b1 && bus.in_valid === 1'b1) begin
        hs.push_back(cyc);
        expq.push_back(model(bus.a, bus.b, bus.c, bus.zero));
        idx++;
        just_hs = 1'b1;
      end
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    vectors++;
    if (got != 3 || hs.size() != 3) begin
      miscompares++;
      $display("FAIL b2b_count: got results=%0d handshakes=%0d want 3 and 3", got, hs.size());
    end else begin
      for (int i = 1; i < 3; i++) begin
        vectors++;
        if (hs[i] - hs[i-1] != 6) begin
          miscompares++;
          $display("FAIL b2b_interval[%0d]: got %0d want 6", i, hs[i] - hs[i-1]);
        end
      end
    end
  endtask

  initial begin
    #200000;
    miscompares++;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vectors       = 0;
    miscompares   = 0;
    clk           = 1'b0;
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    bus.c         = '0;
    bus.zero      = '0;
    repeat (3) @(negedge clk);
    test_reset();
    rst_n = 1'b1;
    test_not_equal();
    test_equal();
    test_wrap();
    test_backpressure();
    test_reset_mid_op();
    test_random();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
